fifo_rd_streamer: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 28 ++
 rtl/rd_skid_buf.sv | 105 ++++++++++
 rtl/fifo_rd_streamer.sv | 107 ++++++++++
 tb/tb_fifo_rd_streamer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared constants and elaboration-time helpers for the dc_fifo read-side
// streamer: legal local-buffer depth range, buffer index width and occupancy
// counter width.
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

   localparam int unsigned BUF_DEPTH_MIN = 2;
   localparam int unsigned BUF_DEPTH_MAX = 16;

   // Depth must lie in [BUF_DEPTH_MIN, BUF_DEPTH_MAX]; 3 or more is needed
   // to sustain one word per cycle.
   function automatic bit buf_depth_ok(input int unsigned depth);
      return (depth >= BUF_DEPTH_MIN) && (depth <= BUF_DEPTH_MAX);
   endfunction

   // Width of a circular-buffer index; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Width able to hold an occupancy of 0..depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// -----------------------------------------------------------------------------
// rd_skid_buf
// Small circular buffer that holds words captured from the FIFO until the
// stream consumer accepts them. Non-power-of-two depths wrap explicitly.
//
// Ports:
//   clk_i        clock
//   srst_i       synchronous active-high reset (indices and occupancy)
//   wr_en_i      capture wr_data_i at the write index this cycle
//   wr_data_i    word to capture
//   rd_ready_i   consumer ready; a pop happens when rd_valid_o && rd_ready_i
//   rd_data_o    head entry (zero while empty)
//   rd_valid_o   buffer non-empty
//   occ_o        current occupancy
//   occ_next_o   occupancy after this cycle's capture/pop
// -----------------------------------------------------------------------------
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter  int unsigned DWIDTH    = 8,
   parameter  int unsigned BUF_DEPTH = 4,
   localparam int unsigned IW        = idx_width(BUF_DEPTH),
   localparam int unsigned OW        = occ_width(BUF_DEPTH)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wr_en_i,
   input  logic [DWIDTH-1:0] wr_data_i,
   input  logic              rd_ready_i,
   output logic [DWIDTH-1:0] rd_data_o,
   output logic              rd_valid_o,
   output logic [OW-1:0]     occ_o,
   output logic [OW-1:0]     occ_next_o
);

   localparam logic [IW-1:0] LAST_IDX = IW'(BUF_DEPTH - 1);

   logic [DWIDTH-1:0] mem_q [BUF_DEPTH];
   logic [IW-1:0]     wr_idx_q, wr_idx_d;
   logic [IW-1:0]     rd_idx_q, rd_idx_d;
   logic [OW-1:0]     occ_q, occ_d;
   logic              pop;

   // Advance an index modulo BUF_DEPTH.
   function automatic logic [IW-1:0] idx_inc(input logic [IW-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + IW'(1);
   endfunction

   // Next-state for indices and occupancy; capture and pop together cancel.
   always_comb begin
      pop      = (occ_q != '0) && rd_ready_i;
      wr_idx_d = wr_idx_q;
      rd_idx_d = rd_idx_q;
      occ_d    = occ_q;
      if (wr_en_i) begin
         wr_idx_d = idx_inc(wr_idx_q);
      end else begin
         wr_idx_d = wr_idx_q;
      end
      if (pop) begin
         rd_idx_d = idx_inc(rd_idx_q);
      end else begin
         rd_idx_d = rd_idx_q;
      end
      case ({wr_en_i, pop})
         2'b10:   occ_d = occ_q + OW'(1);
         2'b01:   occ_d = occ_q - OW'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Index and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         wr_idx_q <= '0;
         rd_idx_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_idx_q <= wr_idx_d;
         rd_idx_q <= rd_idx_d;
         occ_q    <= occ_d;
      end
   end

   // Storage array; a capture landing during reset is dropped.
   always_ff @(posedge clk_i) begin
      if (wr_en_i && !srst_i) begin
         mem_q[wr_idx_q] <= wr_data_i;
      end
   end

   // Head data is forced to zero while empty so reset shows a clean bus.
   always_comb begin
      rd_valid_o = (occ_q != '0);
      rd_data_o  = '0;
      if (rd_valid_o) begin
         rd_data_o = mem_q[rd_idx_q];
      end else begin
         rd_data_o = '0;
      end
      occ_o      = occ_q;
      occ_next_o = occ_d;
   end

endmodule

// File: rtl/fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer
// Read-side drain stage for a normal-mode (non-showahead) dc_fifo. Issues
// read requests while the FIFO is non-empty and the local buffer has room for
// everything already committed, captures the one-cycle-late read data and
// presents it as a valid/ready stream.
//
// Ports:
//   clk_i         FIFO read clock
//   srst_i        synchronous active-high reset
//   fifo_empty_i  FIFO rd_empty_o
//   fifo_q_i      FIFO q_o, valid the cycle after rd_req_o
//   rd_req_o      FIFO rd_req_i
//   src_data_o    stream data (buffer head)
//   src_valid_o   stream valid
//   src_ready_i   stream ready
//   words_o       delivered-word count, wraps modulo 2^CWIDTH
//   busy_o        buffer non-empty or a read in flight
// -----------------------------------------------------------------------------
module fifo_rd_streamer
   import fifo_rd_pkg::*;
#(
   parameter int unsigned DWIDTH    = 8,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned CWIDTH    = 16
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              fifo_empty_i,
   input  logic [DWIDTH-1:0] fifo_q_i,
   output logic              rd_req_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_valid_o,
   input  logic              src_ready_i,
   output logic [CWIDTH-1:0] words_o,
   output logic              busy_o
);

   localparam int unsigned OW = occ_width(BUF_DEPTH);

   if (!buf_depth_ok(BUF_DEPTH)) begin : g_bad_depth
      $error("fifo_rd_streamer: BUF_DEPTH must be in 2..16");
   end

   logic              infl_q, infl_d;
   logic [CWIDTH-1:0] words_q, words_d;
   logic              busy_q, busy_d;
   logic [OW-1:0]     occ, occ_next;
   logic [OW:0]       committed;
   logic              rd_req;
   logic              src_valid;
   logic [DWIDTH-1:0] src_data;

   rd_skid_buf #(
      .DWIDTH    (DWIDTH),
      .BUF_DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .wr_en_i    (infl_q),
      .wr_data_i  (fifo_q_i),
      .rd_ready_i (src_ready_i),
      .rd_data_o  (src_data),
      .rd_valid_o (src_valid),
      .occ_o      (occ),
      .occ_next_o (occ_next)
   );

   // Issue decision uses registered occupancy and in-flight state only, so
   // src_ready_i never reaches rd_req_o combinationally. Counting the
   // in-flight word reserves its slot before the data returns.
   always_comb begin
      committed = {1'b0, occ} + (OW + 1)'(infl_q);
      rd_req    = !fifo_empty_i && (committed < (OW + 1)'(BUF_DEPTH)) && !srst_i;
      infl_d    = rd_req;
      words_d   = words_q;
      if (src_valid && src_ready_i) begin
         words_d = words_q + CWIDTH'(1);
      end else begin
         words_d = words_q;
      end
      busy_d = (occ_next != '0) || infl_d;
   end

   // In-flight flag, delivered-word counter and busy register.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         infl_q  <= 1'b0;
         words_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         infl_q  <= infl_d;
         words_q <= words_d;
         busy_q  <= busy_d;
      end
   end

   // Output drive.
   always_comb begin
      rd_req_o    = rd_req;
      src_data_o  = src_data;
      src_valid_o = src_valid;
      words_o     = words_q;
      busy_o      = busy_q;
   end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
module tb_fifo_rd_streamer;

   logic clk = 1'b0;
   logic srst;

   // Channel A: BUF_DEPTH=4, CWIDTH=16
   logic        a_empty, a_req, a_valid, a_ready, a_busy;
   logic [7:0]  a_q, a_data;
   logic [15:0] a_words;
   // Channel B: BUF_DEPTH=3, CWIDTH=4
   logic        b_empty, b_req, b_valid, b_ready, b_busy;
   logic [7:0]  b_q, b_data;
   logic [3:0]  b_words;

   logic [7:0] fq_a[$], fq_b[$];   // FIFO contents models
   logic [7:0] rx_a[$], rx_b[$];   // words accepted on the stream

   int   n_checks = 0;
   int   n_fail   = 0;
   int   req_cnt_a = 0;
   logic last_req_a, last_req_b, last_valid_a;
   logic [7:0] last_data_a;

   always #5 clk = ~clk;

   fifo_rd_streamer #(.DWIDTH(8), .BUF_DEPTH(4), .CWIDTH(16)) dut_a (
      .clk_i(clk), .srst_i(srst), .fifo_empty_i(a_empty), .fifo_q_i(a_q),
      .rd_req_o(a_req), .src_data_o(a_data), .src_valid_o(a_valid),
      .src_ready_i(a_ready), .words_o(a_words), .busy_o(a_busy));

   fifo_rd_streamer #(.DWIDTH(8), .BUF_DEPTH(3), .CWIDTH(4)) dut_b (
      .clk_i(clk), .srst_i(srst), .fifo_empty_i(b_empty), .fifo_q_i(b_q),
      .rd_req_o(b_req), .src_data_o(b_data), .src_valid_o(b_valid),
      .src_ready_i(b_ready), .words_o(b_words), .busy_o(b_busy));

   // One clock cycle for both channels: present FIFO state, sample outputs
   // before the edge, then model the FIFO's registered q after the edge.
   task automatic tick();
      a_empty = (fq_a.size() == 0);
      b_empty = (fq_b.size() == 0);
      #1;
      last_req_a   = a_req;
      last_req_b   = b_req;
      last_valid_a = a_valid;
      last_data_a  = a_data;
      n_checks += 4;
      if (a_req && a_empty) begin
         n_fail++; $display("FAIL req_while_empty_a: rd_req_o=%0b, required 0", a_req);
      end
      if (b_req && b_empty) begin
         n_fail++; $display("FAIL req_while_empty_b: rd_req_o=%0b, required 0", b_req);
      end
      if (dut_a.infl_q && (dut_a.u_buf.occ_q == 3'd4)) begin
         n_fail++; $display("FAIL capture_full_a: occ=%0d with capture pending", dut_a.u_buf.occ_q);
      end
      if (dut_b.infl_q && (dut_b.u_buf.occ_q == 2'd3)) begin
         n_fail++; $display("FAIL capture_full_b: occ=%0d with capture pending", dut_b.u_buf.occ_q);
      end
      if (a_valid && a_ready) rx_a.push_back(a_data);
      if (b_valid && b_ready) rx_b.push_back(b_data);
      if (a_req) req_cnt_a++;
      @(posedge clk);
      #1;
      if (last_req_a) a_q = fq_a.pop_front();
      if (last_req_b) b_q = fq_b.pop_front();
   endtask

   task automatic test_reset();
      srst = 1'b1;
      for (int i = 1; i <= 5; i++) fq_a.push_back(8'(i));
      for (int i = 0; i < 3; i++) tick();
      n_checks += 7;
      if (last_req_a !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b, required 0", last_req_a); end
      if (a_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %0b, required 0", a_valid); end
      if (a_data !== 8'h00)    begin n_fail++; $display("FAIL reset_data: got %0h, required 00", a_data); end
      if (a_words !== 16'd0)   begin n_fail++; $display("FAIL reset_words: got %0d, required 0", a_words); end
      if (a_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", a_busy); end
      if (b_valid !== 1'b0)    begin n_fail++; $display("FAIL reset_valid_b: got %0b, required 0", b_valid); end
      if (b_words !== 4'd0)    begin n_fail++; $display("FAIL reset_words_b: got %0d, required 0", b_words); end
   endtask

   task automatic test_basic_order();
      logic [9:0] req_bits, valid_bits;
      srst = 1'b0;
      a_ready = 1'b1;
      rx_a.delete();
      for (int i = 0; i < 10; i++) begin
         tick();
         req_bits[i]   = last_req_a;
         valid_bits[i] = last_valid_a;
      end
      n_checks += 4;
      if (req_bits !== 10'b00000_11111) begin
         n_fail++; $display("FAIL basic_req_pattern: got %b, required 0000011111", req_bits);
      end
      if (valid_bits !== 10'b00011_11100) begin
         n_fail++; $display("FAIL basic_valid_pattern: got %b, required 0001111100", valid_bits);
      end
      if (a_words !== 16'd5) begin n_fail++; $display("FAIL basic_words: got %0d, required 5", a_words); end
      if (rx_a.size() != 5) begin n_fail++; $display("FAIL basic_count: got %0d, required 5", rx_a.size()); end
      for (int i = 0; i < rx_a.size() && i < 5; i++) begin
         n_checks++;
         if (rx_a[i] !== 8'(i + 1)) begin
            n_fail++; $display("FAIL basic_data[%0d]: got %0h, required %0h", i, rx_a[i], 8'(i + 1));
         end
      end
   endtask

   task automatic test_backpressure();
      a_ready = 1'b0;
      rx_a.delete();
      for (int i = 0; i < 10; i++) fq_a.push_back(8'(8'h10 + i));
      req_cnt_a = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (last_valid_a) begin
            n_checks++;
            if (last_data_a !== 8'h10) begin
               n_fail++; $display("FAIL bp_hold_data: got %0h, required 10", last_data_a);
            end
         end
      end
      n_checks += 4;
      if (req_cnt_a != 4) begin n_fail++; $display("FAIL bp_req_pulses: got %0d, required 4", req_cnt_a); end
      if (dut_a.u_buf.occ_q !== 3'd4) begin n_fail++; $display("FAIL bp_occ: got %0d, required 4", dut_a.u_buf.occ_q); end
      if (a_busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy: got %0b, required 1", a_busy); end
      if (a_words !== 16'd5) begin n_fail++; $display("FAIL bp_words_hold: got %0d, required 5", a_words); end
      a_ready = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      n_checks += 2;
      if (rx_a.size() != 10) begin n_fail++; $display("FAIL bp_count: got %0d, required 10", rx_a.size()); end
      if (a_words !== 16'd15) begin n_fail++; $display("FAIL bp_words: got %0d, required 15", a_words); end
      for (int i = 0; i < rx_a.size() && i < 10; i++) begin
         n_checks++;
         if (rx_a[i] !== 8'(8'h10 + i)) begin
            n_fail++; $display("FAIL bp_data[%0d]: got %0h, required %0h", i, rx_a[i], 8'(8'h10 + i));
         end
      end
   endtask

   task automatic test_empty_fifo();
      req_cnt_a = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks += 2;
         if (last_valid_a !== 1'b0) begin n_fail++; $display("FAIL empty_valid: got %0b, required 0", last_valid_a); end
         if (a_busy !== 1'b0) begin n_fail++; $display("FAIL empty_busy: got %0b, required 0", a_busy); end
      end
      n_checks++;
      if (req_cnt_a != 0) begin n_fail++; $display("FAIL empty_req: got %0d pulses, required 0", req_cnt_a); end
   endtask

   task automatic test_reset_midflight();
      rx_a.delete();
      fq_a.push_back(8'h30); fq_a.push_back(8'h31); fq_a.push_back(8'h32);
      a_ready = 1'b1;
      tick();
      n_checks++;
      if (last_req_a !== 1'b1) begin n_fail++; $display("FAIL mf_first_req: got %0b, required 1", last_req_a); end
      srst = 1'b1;
      tick();
      n_checks += 6;
      if (last_req_a !== 1'b0) begin n_fail++; $display("FAIL mf_req_in_reset: got %0b, required 0", last_req_a); end
      if (a_req !== 1'b0)      begin n_fail++; $display("FAIL mf_req: got %0b, required 0", a_req); end
      if (a_valid !== 1'b0)    begin n_fail++; $display("FAIL mf_valid: got %0b, required 0", a_valid); end
      if (a_data !== 8'h00)    begin n_fail++; $display("FAIL mf_data: got %0h, required 00", a_data); end
      if (a_busy !== 1'b0)     begin n_fail++; $display("FAIL mf_busy: got %0b, required 0", a_busy); end
      if (a_words !== 16'd0)   begin n_fail++; $display("FAIL mf_words: got %0d, required 0", a_words); end
      srst = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_checks += 2;
      if (rx_a.size() != 2) begin n_fail++; $display("FAIL mf_count: got %0d, required 2", rx_a.size()); end
      if (a_words !== 16'd2) begin n_fail++; $display("FAIL mf_words_after: got %0d, required 2", a_words); end
      if (rx_a.size() == 2) begin
         n_checks += 2;
         if (rx_a[0] !== 8'h31) begin n_fail++; $display("FAIL mf_data0: got %0h, required 31", rx_a[0]); end
         if (rx_a[1] !== 8'h32) begin n_fail++; $display("FAIL mf_data1: got %0h, required 32", rx_a[1]); end
      end
   endtask

   task automatic test_random_ready();
      int pushed = 0;
      int cyc = 0;
      logic [7:0] exp_w;
      rx_b.delete();
      while ((rx_b.size() < 1000) && (cyc < 20000)) begin
         if ((pushed < 1000) && ($urandom_range(0, 1) == 1)) begin
            fq_b.push_back(8'(pushed * 37 + 11));
            pushed++;
         end
         b_ready = ($urandom_range(0, 1) == 1);
         tick();
         cyc++;
      end
      n_checks += 2;
      if (rx_b.size() != 1000) begin n_fail++; $display("FAIL rand_count: got %0d, required 1000", rx_b.size()); end
      if (b_words !== 4'd8) begin n_fail++; $display("FAIL rand_words_mod16: got %0d, required 8", b_words); end
      for (int i = 0; i < rx_b.size(); i++) begin
         exp_w = 8'(i * 37 + 11);
         n_checks++;
         if (rx_b[i] !== exp_w) begin
            n_fail++; $display("FAIL rand_data[%0d]: got %0h, required %0h", i, rx_b[i], exp_w);
         end
      end
   endtask

   task automatic test_counter_wrap();
      srst = 1'b1;
      tick();
      srst = 1'b0;
      n_checks++;
      if (b_words !== 4'd0) begin n_fail++; $display("FAIL wrap_reset: got %0d, required 0", b_words); end
      rx_b.delete();
      for (int i = 0; i < 17; i++) fq_b.push_back(8'(8'h80 + i));
      b_ready = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      n_checks += 2;
      if (rx_b.size() != 17) begin n_fail++; $display("FAIL wrap_count: got %0d, required 17", rx_b.size()); end
      if (b_words !== 4'd1) begin n_fail++; $display("FAIL wrap_words: got %0d, required 1", b_words); end
   endtask

   initial begin
      srst = 1'b1;
      a_ready = 1'b0; b_ready = 1'b0;
      a_q = 8'h00; b_q = 8'h00;
      a_empty = 1'b1; b_empty = 1'b1;
      @(posedge clk);
      #1;
      test_reset();
      test_basic_order();
      test_backpressure();
      test_empty_fifo();
      test_reset_midflight();
      test_random_ready();
      test_counter_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
